// File: rtl/pid_pwm_out_if.sv
// MV update bus from the PID core into the PWM actuator stage.
// The core drives the master side; pid_pwm_out takes the slave side.
interface pid_pwm_out_if #(
  parameter int CNT_W = 16
);
  logic signed [31:0] MV_in;
  logic               MV_valid;
  logic [CNT_W-1:0]   period_in;

  modport master (
    output MV_in,
    output MV_valid,
    output period_in
  );

  modport slave (
    input MV_in,
    input MV_valid,
    input period_in
  );
endinterface

// File: rtl/pid_pwm_out.sv
// PID MV to PWM actuator stage with double-buffered duty/period.
// Optional dead-time insertion enabled by defining PWM_DEADTIME_EN.
module pid_pwm_out #(
  parameter int CNT_W      = 16,
  parameter int SHIFT      = 0,
  parameter int PERIOD_RST = 1000,
  parameter int DEAD       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  pid_pwm_out_if.slave     mv_if,
  output logic             pwm_out,
  output logic             pwm_n_out,
  output logic [CNT_W-1:0] duty,
  output logic [1:0]       sat,
  output logic             period_tick
);

  localparam logic [CNT_W-1:0] PER_RST_C = CNT_W'(PERIOD_RST);
  localparam logic [CNT_W-1:0] PER_MIN_C = CNT_W'(2);

  logic signed [31:0] mv_r;
  logic [CNT_W-1:0]   per_r;
  logic               s1_v;

  logic [CNT_W-1:0]   duty_c;
  logic [1:0]         sat_c;

  logic [CNT_W-1:0]   duty_pend;
  logic [CNT_W-1:0]   per_pend;
  logic [1:0]         sat_pend;
  logic               pend;

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   duty_act;
  logic [CNT_W-1:0]   period_act;
  logic [1:0]         sat_act;

  logic               wrap;
  logic               load;
  logic               pwm_raw;

  // Stage 1: capture scaled MV and clamped period on the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      mv_r  <= '0;
      per_r <= PER_MIN_C;
      s1_v  <= 1'b0;
    end else begin
      s1_v <= mv_if.MV_valid;
      if (mv_if.MV_valid) begin
        mv_r  <= mv_if.MV_in >>> SHIFT;
        per_r <= (mv_if.period_in < PER_MIN_C) ? PER_MIN_C
                                               : mv_if.period_in;
      end
    end
  end

  // Saturate the captured MV against its own requested period
  always_comb begin
    duty_c = mv_r[CNT_W-1:0];
    sat_c  = 2'b00;
    if (mv_r < 0) begin
      duty_c = '0;
      sat_c  = 2'b01;
    end else if ($unsigned(mv_r) > 32'(per_r)) begin
      duty_c = per_r;
      sat_c  = 2'b10;
    end
  end

  assign wrap    = (cnt == period_act - 1'b1);
  assign load    = pend && (en ? wrap : 1'b1);
  assign pwm_raw = (cnt < duty_act);

  // Stage 2: pending buffer; a new write outranks a same-edge load
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_pend <= '0;
      per_pend  <= PER_RST_C;
      sat_pend  <= 2'b00;
      pend      <= 1'b0;
    end else begin
      if (s1_v) begin
        duty_pend <= duty_c;
        per_pend  <= per_r;
        sat_pend  <= sat_c;
        pend      <= 1'b1;
      end else if (load) begin
        pend <= 1'b0;
      end
    end
  end

  // Period counter and active registers, updated only at boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      duty_act    <= '0;
      period_act  <= PER_RST_C;
      sat_act     <= 2'b00;
      period_tick <= 1'b0;
    end else begin
      period_tick <= 1'b0;
      if (!en) begin
        cnt <= '0;
      end else if (wrap) begin
        cnt         <= '0;
        period_tick <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        duty_act   <= duty_pend;
        period_act <= per_pend;
        sat_act    <= sat_pend;
      end
    end
  end

  assign duty = duty_act;
  assign sat  = sat_act;

`ifdef PWM_DEADTIME_EN
  localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);

  logic             raw_q;
  logic [CNT_W-1:0] age_q;
  logic [CNT_W-1:0] age_c;
  logic             dt_ok;

  // Cycles since the last raw transition, saturating at DEAD
  always_comb begin
    age_c = '0;
    if (en && (pwm_raw == raw_q))
      age_c = (age_q >= DEAD_C) ? DEAD_C : age_q + 1'b1;
  end

  assign dt_ok = (age_c >= DEAD_C);

  // Outputs: rising edges held off until the dead-time expires
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q     <= 1'b0;
      age_q     <= '0;
      pwm_out   <= 1'b0;
      pwm_n_out <= 1'b0;
    end else begin
      raw_q     <= pwm_raw;
      age_q     <= age_c;
      pwm_out   <= en & pwm_raw & dt_ok;
      pwm_n_out <= en & ~pwm_raw & dt_ok;
    end
  end
`else
  // Outputs: registered raw compare and its gated complement
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out   <= 1'b0;
      pwm_n_out <= 1'b0;
    end else begin
      pwm_out   <= en & pwm_raw;
      pwm_n_out <= en & ~pwm_raw;
    end
  end
`endif

endmodule
